comparador_lock: RTL and testbench

- Sequential lock controller directly downstream of the 2-bit equality comparator (comparador).
- Consumes the comparator's match bit X, one digit at a time, and decides unlock or fail after a full code sequence.
- Drives step_o back to the key-digit mux that feeds the comparator's B input.
- Adds fail counting, timed lockout and a timed open window.

---
 rtl/lock_pkg.sv | 21 ++
 rtl/lock_timer.sv | 30 +++
 rtl/comparador_lock.sv | 167 ++++++++++++++++
 tb/tb_comparador_lock.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the comparador_lock controller.
package lock_pkg;

    typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} lock_state_t;

    localparam int unsigned MinWidth = 1;

    function automatic int unsigned step_width(int unsigned seq_len);
        return (seq_len > 1) ? $clog2(seq_len) : MinWidth;
    endfunction

    function automatic int unsigned fail_width(int unsigned max_fails);
        return (max_fails > 0) ? $clog2(max_fails + 1) : MinWidth;
    endfunction

    // The timer is loaded with cycles-1, so it only needs to hold max_cycles-1.
    function automatic int unsigned timer_width(int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : MinWidth;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired pulses while enabled and the count has reached zero.
module lock_timer
    import lock_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 16,
    localparam int unsigned W = timer_width(MAX_CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/comparador_lock.sv
// Code-sequence lock controller fed by the comparator match bit.
// Optional entry timeout enabled by defining LOCK_TIMEOUT_EN.
module comparador_lock
    import lock_pkg::*;
#(
    parameter int unsigned SEQ_LEN        = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    localparam int unsigned SW = step_width(SEQ_LEN),
    localparam int unsigned FW = fail_width(MAX_FAILS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          try_i,
    input  logic          match_i,
    input  logic          relock_i,
    output logic [SW-1:0] step_o,
    output logic          busy_o,
    output logic          unlocked_o,
    output logic          locked_out_o,
    output logic [FW-1:0] fail_cnt_o
);

    localparam int unsigned WinMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW = timer_width(WinMax);
    localparam logic [SW-1:0] LastStep = SW'(SEQ_LEN - 1);
    localparam logic [FW-1:0] MaxFails = FW'(MAX_FAILS);
    localparam logic [TW-1:0] OpenLoad = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LockLoad = TW'(LOCKOUT_CYCLES - 1);

    lock_state_t   state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          err_q, err_d;
    logic          busy_q, unlocked_q, locked_out_q;
    logic [FW-1:0] fail_next;
    logic          seq_fail;
    logic          win_load, win_en, win_expired;
    logic [TW-1:0] win_val;
    logic          ent_expired;

    lock_timer #(
        .MAX_CYCLES (WinMax)
    ) u_win_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (win_val),
        .en       (win_en),
        .expired  (win_expired)
    );

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned EW = timer_width(TIMEOUT_CYCLES);

    logic ent_load, ent_en;

    // Every accepted digit restarts the idle window, including one on the expiring cycle.
    assign ent_load = try_i && ((state_q == IDLE) || (state_q == ENTRY));
    assign ent_en   = (state_q == ENTRY) && !try_i;

    lock_timer #(
        .MAX_CYCLES (TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ent_load),
        .load_val (EW'(TIMEOUT_CYCLES - 1)),
        .en       (ent_en),
        .expired  (ent_expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign ent_expired    = 1'b0;
`endif

    assign win_en    = (state_q == OPEN) || (state_q == LOCKOUT);
    assign fail_next = (fail_q == MaxFails) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        err_d    = err_q;
        fail_d   = fail_q;
        seq_fail = 1'b0;
        win_load = 1'b0;
        win_val  = '0;
        case (state_q)
            IDLE, ENTRY: begin
                if (try_i) begin
                    if (step_q == LastStep) begin
                        step_d = '0;
                        err_d  = 1'b0;
                        if (!err_q && match_i) begin
                            state_d  = OPEN;
                            fail_d   = '0;
                            win_load = 1'b1;
                            win_val  = OpenLoad;
                        end else begin
                            seq_fail = 1'b1;
                        end
                    end else begin
                        // Wrong digits are only remembered, never revealed mid-sequence.
                        step_d  = step_q + 1'b1;
                        err_d   = err_q | ~match_i;
                        state_d = ENTRY;
                    end
                end else if ((state_q == ENTRY) && ent_expired) begin
                    step_d   = '0;
                    err_d    = 1'b0;
                    seq_fail = 1'b1;
                end
            end
            OPEN: begin
                if (relock_i || win_expired) state_d = IDLE;
            end
            LOCKOUT: begin
                if (win_expired) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (seq_fail) begin
            fail_d = fail_next;
            if (fail_next == MaxFails) begin
                state_d  = LOCKOUT;
                win_load = 1'b1;
                win_val  = LockLoad;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            err_q        <= 1'b0;
            fail_q       <= '0;
            busy_q       <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
            busy_q       <= (step_d != '0);
            unlocked_q   <= (state_d == OPEN);
            locked_out_q <= (state_d == LOCKOUT);
        end
    end

    assign step_o       = step_q;
    assign busy_o       = busy_q;
    assign unlocked_o   = unlocked_q;
    assign locked_out_o = locked_out_q;
    assign fail_cnt_o   = fail_q;

endmodule

// File: tb/tb_comparador_lock.sv
// Scoreboard bench for comparador_lock: a cycle model queues expected outputs per driven cycle.
module tb_comparador_lock;

    localparam int SEQ_LEN        = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int OPEN_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       try_i = 1'b0;
    logic       match_i = 1'b0;
    logic       relock_i = 1'b0;
    logic [1:0] step_o;
    logic       busy_o;
    logic       unlocked_o;
    logic       locked_out_o;
    logic [1:0] fail_cnt_o;

    comparador_lock #(
        .SEQ_LEN        (SEQ_LEN),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .try_i        (try_i),
        .match_i      (match_i),
        .relock_i     (relock_i),
        .step_o       (step_o),
        .busy_o       (busy_o),
        .unlocked_o   (unlocked_o),
        .locked_out_o (locked_out_o),
        .fail_cnt_o   (fail_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int busy;
        int unl;
        int lo;
        int fail;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: 0 idle, 1 entry, 2 open, 3 lockout.
    int m_state = 0, m_step = 0, m_err = 0, m_fail = 0, m_win = 0, m_idle = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_fail();
        if (m_fail < MAX_FAILS) m_fail++;
        if (m_fail == MAX_FAILS) begin
            m_state = 3;
            m_win   = LOCKOUT_CYCLES;
        end else begin
            m_state = 0;
        end
        m_step = 0;
        m_err  = 0;
        m_idle = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit m, input bit rl);
        if (r) begin
            m_state = 0; m_step = 0; m_err = 0; m_fail = 0; m_win = 0; m_idle = 0;
        end else begin
            case (m_state)
                0, 1: begin
                    if (t) begin
                        m_idle = 0;
                        if (m_step == SEQ_LEN - 1) begin
                            if (m_err == 0 && m) begin
                                m_state = 2;
                                m_win   = OPEN_CYCLES;
                                m_fail  = 0;
                                m_step  = 0;
                                m_err   = 0;
                            end else begin
                                model_fail();
                            end
                        end else begin
                            m_step++;
                            if (!m) m_err = 1;
                            m_state = 1;
                        end
                    end else if (m_state == 1) begin
`ifdef LOCK_TIMEOUT_EN
                        m_idle++;
                        if (m_idle == TIMEOUT_CYCLES) model_fail();
`endif
                    end
                end
                2: begin
                    m_win--;
                    if (rl || m_win == 0) m_state = 0;
                end
                default: begin
                    m_win--;
                    if (m_win == 0) begin
                        m_state = 0;
                        m_fail  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input bit t, input bit m, input bit rl, input bit r);
        exp_t e;
        @(negedge clk);
        rst      = r;
        try_i    = t;
        match_i  = m;
        relock_i = rl;
        model_step(r, t, m, rl);
        e.step = m_step;
        e.busy = (m_step != 0) ? 1 : 0;
        e.unl  = (m_state == 2) ? 1 : 0;
        e.lo   = (m_state == 3) ? 1 : 0;
        e.fail = m_fail;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic good_seq();
        for (int i = 0; i < SEQ_LEN; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic bad_seq();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("step", 32'(step_o), e.step);
            check_val("busy", 32'(busy_o), e.busy);
            check_val("unlocked", 32'(unlocked_o), e.unl);
            check_val("locked_out", 32'(locked_out_o), e.lo);
            check_val("fail_cnt", 32'(fail_cnt_o), e.fail);
        end
    end

    initial begin
        int cnt;

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Correct code: count the open window length directly as well.
        good_seq();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (unlocked_o) cnt++;
        end
        check_val("open_len", cnt, OPEN_CYCLES);

        // Wrong second digit, then two more failures into lockout.
        bad_seq();
        idle(2);
        bad_seq();
        idle(1);
        bad_seq();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc((i % 3) == 0, 1'b1, (i % 5) == 0, 1'b0);
            if (locked_out_o) cnt++;
        end
        check_val("lockout_len", cnt, LOCKOUT_CYCLES);

        // Early relock on the third open cycle, then relock while idle.
        good_seq();
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset mid-entry, then a clean unlock.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        good_seq();
        idle(3);

        // Relock coinciding with the last open cycle.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        good_seq();
        idle(OPEN_CYCLES - 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Single digit followed by a long gap exercises the entry timeout.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(TIMEOUT_CYCLES + 2);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
